// File: rtl/board_access_ctrl.sv
// Board memory arbiter and clear sequencer.
// Shares one port between writer, checker, display and wipe.
module board_access_ctrl #(
  parameter int ROW_BITS  = 3,
  parameter int COL_BITS  = 3,
  parameter int AGE_LIMIT = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_req,
  input  logic [ROW_BITS-1:0] wr_row,
  input  logic [COL_BITS-1:0] wr_col,
  input  logic [1:0]          wr_data,
  output logic                wr_gnt,
  input  logic                chk_req,
  input  logic [ROW_BITS-1:0] chk_row,
  input  logic [COL_BITS-1:0] chk_col,
  output logic                chk_gnt,
  output logic                chk_rvalid,
  input  logic                disp_req,
  input  logic [ROW_BITS-1:0] disp_row,
  input  logic [COL_BITS-1:0] disp_col,
  output logic                disp_gnt,
  output logic                disp_rvalid,
  output logic [1:0]          rdata,
  input  logic                clr_start,
  output logic                clr_busy,
  output logic                clr_done,
  output logic [ROW_BITS-1:0] mem_row,
  output logic [COL_BITS-1:0] mem_col,
  output logic                mem_we,
  output logic [1:0]          mem_wdata,
  input  logic [1:0]          mem_rdata
);

  localparam int CW = ROW_BITS + COL_BITS;
  localparam logic [CW-1:0] LAST = '1;
  localparam logic [2:0] AGE_LIM3 = 3'(AGE_LIMIT);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      age_q;
  logic [1:0]      rdata_q;
  logic            chk_rvalid_q;
  logic            disp_rvalid_q;
  logic            clr_busy_q;
  logic            clr_done_q;

  logic            arb_ok;
  logic            clearing;
  logic            promo;

  assign arb_ok   = (state_q == IDLE) && !rst && !clr_start;
  assign clearing = (state_q == CLEAR) && !rst;
  assign promo    = disp_req && (age_q >= AGE_LIM3);

  // Fixed-priority grant with aged display promotion.
  always_comb begin
    wr_gnt   = arb_ok && wr_req;
    disp_gnt = arb_ok && !wr_req && disp_req
               && (promo || !chk_req);
    chk_gnt  = arb_ok && !wr_req && chk_req && !promo;
  end

  // Memory port mux: sweep address or granted requester.
  always_comb begin
    mem_row   = '0;
    mem_col   = '0;
    mem_we    = 1'b0;
    mem_wdata = wr_data;
    unique case (1'b1)
      clearing: begin
        mem_row   = cnt_q[CW-1:COL_BITS];
        mem_col   = cnt_q[COL_BITS-1:0];
        mem_we    = 1'b1;
        mem_wdata = 2'b00;
      end
      wr_gnt: begin
        mem_row = wr_row;
        mem_col = wr_col;
        mem_we  = 1'b1;
      end
      chk_gnt: begin
        mem_row = chk_row;
        mem_col = chk_col;
      end
      disp_gnt: begin
        mem_row = disp_row;
        mem_col = disp_col;
      end
      default: ;
    endcase
  end

  // Control FSM, sweep counter, aging and read return.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      age_q         <= 3'd0;
      rdata_q       <= 2'b00;
      chk_rvalid_q  <= 1'b0;
      disp_rvalid_q <= 1'b0;
      clr_busy_q    <= 1'b0;
      clr_done_q    <= 1'b0;
    end else begin
      clr_done_q    <= 1'b0;
      chk_rvalid_q  <= chk_gnt;
      disp_rvalid_q <= disp_gnt;
      if (chk_gnt || disp_gnt)
        rdata_q <= mem_rdata;
      if (!disp_req || disp_gnt)
        age_q <= 3'd0;
      else if (age_q != 3'd7)
        age_q <= age_q + 3'd1;
      unique case (state_q)
        IDLE: begin
          if (clr_start) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            clr_busy_q <= 1'b1;
          end
        end
        CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q    <= IDLE;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdata       = rdata_q;
  assign chk_rvalid  = chk_rvalid_q;
  assign disp_rvalid = disp_rvalid_q;
  assign clr_busy    = clr_busy_q;
  assign clr_done    = clr_done_q;

endmodule

// File: tb/tb_board_access_ctrl.sv
// Scoreboard bench for board_access_ctrl.
// Board memory model plus cycle-level reference of the arbiter.
module tb_board_access_ctrl;

  localparam int AGE = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_req, chk_req, disp_req, clr_start;
  logic [2:0] wr_row, wr_col, chk_row, chk_col;
  logic [2:0] disp_row, disp_col;
  logic [1:0] wr_data;
  logic       wr_gnt, chk_gnt, disp_gnt;
  logic       chk_rvalid, disp_rvalid;
  logic [1:0] rdata;
  logic       clr_busy, clr_done;
  logic [2:0] mem_row, mem_col;
  logic       mem_we;
  logic [1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  logic [1:0] mem [64];
  logic [1:0] ref_board [64];

  assign mem_rdata = mem[{mem_row, mem_col}];

  always @(posedge clk)
    if (mem_we) mem[{mem_row, mem_col}] <= mem_wdata;

  board_access_ctrl #(
    .ROW_BITS(3), .COL_BITS(3), .AGE_LIMIT(AGE)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data), .wr_gnt(wr_gnt),
    .chk_req(chk_req), .chk_row(chk_row), .chk_col(chk_col),
    .chk_gnt(chk_gnt), .chk_rvalid(chk_rvalid),
    .disp_req(disp_req), .disp_row(disp_row),
    .disp_col(disp_col), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .rdata(rdata),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .clr_done(clr_done),
    .mem_row(mem_row), .mem_col(mem_col),
    .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         owner;
    logic [1:0] data;
    int         due;
  } rd_t;
  rd_t q[$];

  int m_age = 0;
  int m_cell = 0;
  bit m_clear = 0;
  bit m_done = 0;
  int last_win = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d",
               name, cyc, act, exp);
    end
  endtask

  // Read-return monitor: pops one expectation per rvalid.
  rd_t e;
  always @(negedge clk) begin
    if (chk_rvalid || disp_rvalid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected cycle %0d: got rvalid expected none",
                 cyc);
      end else begin
        e = q.pop_front();
        check("rd_owner", {30'd0, disp_rvalid, chk_rvalid},
              (e.owner == 1) ? 32'd1 : 32'd2);
        check("rd_latency", cyc, e.due);
        check("rdata", {30'd0, rdata}, {30'd0, e.data});
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      checks++;
      errors++;
      $display("FAIL rd_missing cycle %0d: got no rvalid expected due %0d",
               cyc, q[0].due);
      void'(q.pop_front());
    end
  end

  // One clock of reference model: predict, compare, advance.
  task automatic step();
    int win;
    bit clr_cyc;
    int er, ec, a;
    @(negedge clk);
    clr_cyc = !rst && m_clear;
    win = 0;
    if (!rst && !m_clear && !clr_start) begin
      if (wr_req) win = 1;
      else if (chk_req && !(disp_req && m_age >= AGE)) win = 2;
      else if (disp_req) win = 3;
    end
    er = 0;
    ec = 0;
    if (clr_cyc) begin
      er = m_cell / 8;
      ec = m_cell % 8;
    end else if (win == 1) begin
      er = wr_row;
      ec = wr_col;
    end else if (win == 2) begin
      er = chk_row;
      ec = chk_col;
    end else if (win == 3) begin
      er = disp_row;
      ec = disp_col;
    end
    check("wr_gnt", wr_gnt, win == 1);
    check("chk_gnt", chk_gnt, win == 2);
    check("disp_gnt", disp_gnt, win == 3);
    check("mem_we", mem_we, (win == 1) || clr_cyc);
    check("mem_row", mem_row, er);
    check("mem_col", mem_col, ec);
    if ((win == 1) || clr_cyc)
      check("mem_wdata", mem_wdata,
            clr_cyc ? 32'd0 : {30'd0, wr_data});
    check("clr_busy", clr_busy, m_clear);
    check("clr_done", clr_done, m_done);
    a = er * 8 + ec;
    if (win == 2 || win == 3)
      q.push_back('{owner: win - 1, data: ref_board[a], due: cyc + 1});
    last_win = win;
    @(posedge clk);
    if (rst) begin
      m_clear = 0;
      m_done = 0;
      m_age = 0;
    end else begin
      m_done = 0;
      if (m_clear) begin
        ref_board[m_cell] = 2'b00;
        m_cell++;
        if (m_cell == 64) begin
          m_clear = 0;
          m_done = 1;
        end
      end else if (clr_start) begin
        m_clear = 1;
        m_cell = 0;
      end else if (win == 1) begin
        ref_board[a] = wr_data;
      end
      if (disp_req && win != 3)
        m_age = (m_age < 7) ? m_age + 1 : 7;
      else
        m_age = 0;
    end
    #1;
  endtask

  task automatic idle_in();
    wr_req = 0;
    chk_req = 0;
    disp_req = 0;
    clr_start = 0;
  endtask

  initial begin
    int first_disp;
    int wr_wait;
    rst = 1;
    idle_in();
    wr_row = 0; wr_col = 0; wr_data = 0;
    chk_row = 0; chk_col = 0;
    disp_row = 0; disp_col = 0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 2'($urandom_range(0, 3));
      ref_board[i] = mem[i];
    end
    mem[21] = 2'b01;
    ref_board[21] = 2'b01;

    @(posedge clk);
    #1;
    step();
    check("rst_rdata", {30'd0, rdata}, 0);
    check("rst_chk_rvalid", chk_rvalid, 0);
    check("rst_disp_rvalid", disp_rvalid, 0);
    rst = 0;

    chk_req = 1; chk_row = 2; chk_col = 5;
    step();
    idle_in();
    step();

    wr_req = 1; wr_row = 1; wr_col = 1; wr_data = 2'b11;
    chk_req = 1; chk_row = 1; chk_col = 1;
    disp_req = 1; disp_row = 4; disp_col = 4;
    step();
    check("prio_wr_first", last_win, 1);
    wr_req = 0;
    step();
    check("prio_chk_next", last_win, 2);
    idle_in();
    step();

    chk_req = 1;
    disp_req = 1;
    first_disp = -1;
    for (int i = 0; i < 20; i++) begin
      chk_row = 3'($urandom); chk_col = 3'($urandom);
      disp_row = 3'($urandom); disp_col = 3'($urandom);
      step();
      if (last_win == 3 && first_disp < 0) first_disp = i;
    end
    check("aging_first_disp", first_disp, AGE);
    idle_in();
    step();

    clr_start = 1;
    step();
    clr_start = 0;
    wr_req = 1; wr_row = 3; wr_col = 4; wr_data = 2'b10;
    wr_wait = 0;
    for (int i = 0; i < 70 && last_win != 1; i++) begin
      clr_start = (i == 10);
      step();
      wr_wait++;
    end
    clr_start = 0;
    check("clear_wr_grant_cycle", wr_wait, 65);
    idle_in();
    step();

    clr_start = 1;
    step();
    clr_start = 0;
    for (int i = 0; i < 20; i++) step();
    rst = 1;
    step();
    rst = 0;
    for (int i = 0; i < 3; i++) step();
    clr_start = 1;
    step();
    clr_start = 0;
    for (int i = 0; i < 66; i++) step();

    wr_req = 1; wr_row = 0; wr_col = 3; wr_data = 2'b10;
    step();
    wr_req = 0;
    chk_req = 1; chk_row = 0; chk_col = 3;
    step();
    idle_in();
    step();

    for (int i = 0; i < 2000; i++) begin
      wr_req    = ($urandom_range(0, 3) == 0);
      chk_req   = $urandom_range(0, 1) == 1;
      disp_req  = $urandom_range(0, 1) == 1;
      clr_start = ($urandom_range(0, 149) == 0);
      rst       = ($urandom_range(0, 399) == 0);
      wr_row = 3'($urandom); wr_col = 3'($urandom);
      wr_data = 2'($urandom);
      chk_row = 3'($urandom); chk_col = 3'($urandom);
      disp_row = 3'($urandom); disp_col = 3'($urandom);
      step();
    end
    rst = 0;
    idle_in();
    for (int i = 0; i < 3; i++) step();
    check("queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/board_access_ctrl.md
# board_access_ctrl

Arbiter and sequencer for the single-port 8x8 Connect Four board memory. It shares one address/data port between four users: the game FSM writing a piece, the victory checker reading cells, a display scanner reading cells, and a built-in clear sequencer that wipes the board for a new game. It sits between those requesters and the board read/write block, and it tags returned read data so each reader knows the data belongs to it.

## Interface
Parameters:
- ROW_BITS, 3, row index width (ROWS = 2**ROW_BITS)
- COL_BITS, 3, column index width (COLS = 2**COL_BITS)
- AGE_LIMIT, 7, number of consecutive denied display cycles before display is promoted above the checker

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- wr_req  in  1  game FSM write request, level, held until granted
- wr_row / wr_col / wr_data  in  3/3/2  write address and player ID
- wr_gnt  out  1  write accepted this cycle
- chk_req  in  1  victory-checker read request, level
- chk_row / chk_col  in  3/3  checker read address
- chk_gnt  out  1  checker read accepted this cycle
- chk_rvalid  out  1  chk_rdata valid (one cycle after chk_gnt)
- disp_req  in  1  display read request, level
- disp_row / disp_col  in  3/3  display read address
- disp_gnt  out  1  display read accepted this cycle
- disp_rvalid  out  1  disp_rdata valid (one cycle after disp_gnt)
- rdata  out  2  registered read data, shared by both readers, qualified by the rvalid flags
- clr_start  in  1  one-cycle pulse that starts a board wipe
- clr_busy  out  1  wipe in progress
- clr_done  out  1  one-cycle pulse after the last cell is cleared
- mem_row / mem_col  out  3/3  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  2  memory write data
- mem_rdata  in  2  memory read data, combinational from mem_row/mem_col

## Operation
- FSM states:
  - IDLE: arbitrate requests.
  - CLEAR: wipe the board.
- IDLE -> CLEAR on clr_start. If clr_start arrives in the same cycle as requests, clear wins and no grant is issued that cycle.
- CLEAR -> IDLE after the final cell.
- Arbitration in IDLE is combinational, with at most one grant per cycle. Fixed priority:
  - Write beats display and checker.
  - Checker beats display, except when the age counter is at or above AGE_LIMIT.
  - In that case display beats checker, but still not write.
- Age counter:
  - 3 bits, saturating.
  - Increments each cycle that disp_req=1 and disp_gnt=0.
  - Clears on disp_gnt or when disp_req=0.
- Mux rules:
  - The granted requester's address drives mem_row/mem_col.
  - mem_we = wr_gnt; mem_wdata = wr_data.
  - With no grant, address = 0 and mem_we = 0.
- Read return:
  - On a read grant, mem_rdata is registered into rdata.
  - The matching rvalid is set next cycle for exactly one cycle.
- CLEAR sequencing:
  - A 6-bit cell counter starts at 0 and walks row-major: row = cnt[5:3], col = cnt[2:0].
  - Each cycle: mem_we=1, mem_wdata=00, clr_busy=1, all grants 0.
  - After cell 63: clr_done=1 for one cycle, return to IDLE, clr_busy=0 in that same cycle.
- clr_start during CLEAR is ignored; the sweep does not restart.
- Requests that are held through CLEAR are served in priority order afterwards. Read data is never returned for an ungranted request.

## Timing
- Reset (rst=1 at a clock edge) sets:
  - state to IDLE, cell counter and age counter to 0;
  - rdata=00, chk_rvalid=0, disp_rvalid=0, clr_busy=0, clr_done=0.
- Reset mid-CLEAR aborts the sweep with no clr_done pulse.
- Combinational outputs during reset:
  - All grants are forced to 0 while rst=1.
  - mem_we=0, mem_row=0, mem_col=0.
- Grant latency: 0 cycles (same cycle as request, if the request wins).
- Read latency: grant at cycle N -> rvalid and rdata at cycle N+1. Back-to-back reads give one result per cycle.
- Write takes effect at the edge ending the grant cycle. A read of the same cell granted the next cycle returns the new value.
- Clear duration:
  - clr_start at cycle N -> clr_busy high for cycles N+1..N+64 (one cell cleared per cycle).
  - clr_done high at cycle N+65.
  - Grants possible from cycle N+65.
- Starvation bound: display is granted within AGE_LIMIT+1 cycles of disp_req rising, unless wr_req or CLEAR intervenes.

## Test plan
- Reset values: assert rst for 2 cycles -> all outputs 0. Then chk_req at (2,5) with mem_rdata=01 -> chk_gnt same cycle, chk_rvalid=1 and rdata=01 next cycle.
- Priority: wr_req, chk_req and disp_req all high in one cycle -> only wr_gnt=1 and mem_we=1. Next cycle (wr_req dropped) -> chk_gnt=1 and disp_gnt=0.
- Aging: chk_req and disp_req held high continuously -> checker is granted for 7 cycles, display is granted on cycle 8 (age counter = 7), then the checker resumes.
- Clear: clr_start pulse -> 64 consecutive writes of 00 covering addresses (0,0)..(7,7) in row-major order, clr_busy=1 throughout. clr_done pulses once at N+65; a wr_req held during the sweep is granted at N+65.
- Abort: rst asserted at sweep cell 20 -> no clr_done, clr_busy=0. A new clr_start then sweeps again from (0,0).
- Write-then-read: write 10 to (0,3), then checker reads (0,3) the next cycle -> chk_rvalid=1 with rdata=10 (requires a board memory model in the bench).
